data_memory_be: RTL and testbench

DATA_MEMORY_BE -- requirements
Module: data_memory_be

---
 rtl/data_memory_be.sv | 141 ++++++++++++++
 tb/tb_data_memory_be.sv | 232 +++++++++++++++++++++++
 2 files changed

// File: rtl/data_memory_be.sv
// Byte-enabled data memory: 32-bit little-endian words, byte/half/word loads and stores,
// programmable response latency with a single outstanding request.
module data_memory_be #(
   parameter int unsigned DEPTH   = 2048,
   parameter int unsigned LATENCY = 1
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        req,
   input  logic        we,
   input  logic [1:0]  size,
   input  logic        uns,
   input  logic [31:0] a,
   input  logic [31:0] wd,
   output logic        ready,
   output logic        rvalid,
   output logic [31:0] rd,
   output logic        err
);

   localparam int unsigned AW = $clog2(DEPTH);
   // Counter value loaded on acceptance; unused when LATENCY is 1.
   localparam logic [1:0] CntLoad = (LATENCY > 1) ? 2'(LATENCY - 2) : 2'd0;

   typedef enum logic [1:0] {StIdle, StWait, StResp} state_e;

   state_e      state_q, state_d;
   logic [1:0]  cnt_q, cnt_d;
   logic [31:0] rdata_q, rdata_d;
   logic        err_q, err_d;

   // Contents start at zero and are never touched by reset.
   logic [31:0] mem [DEPTH] = '{default: 32'h0};

   logic          accept;
   logic          req_err;
   logic [AW-1:0] widx;
   logic [3:0]    lane_be;
   logic [31:0]   wr_data;
   logic [31:0]   rd_word;
   logic [7:0]    sel_byte;
   logic [15:0]  sel_half;
   logic [31:0]   load_val;

   // Response outputs are forced to zero outside the response cycle.
   always_comb begin
      ready  = (state_q != StWait);
      rvalid = (state_q == StResp);
      rd     = rvalid ? rdata_q : 32'h0;
      err    = rvalid & err_q;
   end

   // Request decode: legality, lane enables, replicated store data and load extraction.
   always_comb begin
      accept  = req && ready && !reset;
      widx    = a[AW+1:2];
      req_err = (size == 2'b11)
             || ((size == 2'b01) && a[0])
             || ((size == 2'b10) && (a[1:0] != 2'b00))
             || ({2'b00, a[31:2]} >= DEPTH);

      lane_be = 4'b0000;
      wr_data = wd;
      case (size)
         2'b00: begin
            lane_be = 4'b0001 << a[1:0];
            wr_data = {4{wd[7:0]}};
         end
         2'b01: begin
            lane_be = 4'b0011 << a[1:0];
            wr_data = {2{wd[15:0]}};
         end
         2'b10:   lane_be = 4'b1111;
         default: lane_be = 4'b0000;
      endcase

      rd_word  = mem[widx];
      sel_byte = rd_word[{a[1:0], 3'b000} +: 8];
      sel_half = rd_word[{a[1], 4'b0000} +: 16];
      case (size)
         2'b00:   load_val = uns ? {24'h0, sel_byte} : {{24{sel_byte[7]}}, sel_byte};
         2'b01:   load_val = uns ? {16'h0, sel_half} : {{16{sel_half[15]}}, sel_half};
         default: load_val = rd_word;
      endcase
   end

   // Next-state: latency sequencing and capture of the response at acceptance.
   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      rdata_d = rdata_q;
      err_d   = err_q;

      case (state_q)
         StWait: begin
            if (cnt_q == 2'd0) begin
               state_d = StResp;
            end else begin
               cnt_d = cnt_q - 2'd1;
            end
         end
         StResp:  state_d = StIdle;
         default: state_d = StIdle;
      endcase

      // Acceptance is only possible in IDLE or RESP; in RESP it restarts the sequence.
      if (accept) begin
         state_d = (LATENCY == 1) ? StResp : StWait;
         cnt_d   = CntLoad;
         err_d   = req_err;
         rdata_d = (req_err || we) ? 32'h0 : load_val;
      end
   end

   // Control and response registers with synchronous reset.
   always_ff @(posedge clk) begin
      if (reset) begin
         state_q <= StIdle;
         cnt_q   <= 2'd0;
         rdata_q <= 32'h0;
         err_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         rdata_q <= rdata_d;
         err_q   <= err_d;
      end
   end

   // Store commits at the acceptance edge, only on enabled lanes of a legal request.
   always_ff @(posedge clk) begin
      if (accept && we && !req_err) begin
         for (int k = 0; k < 4; k++) begin
            if (lane_be[k]) begin
               mem[widx][8*k +: 8] <= wr_data[8*k +: 8];
            end
         end
      end
   end

endmodule

// File: tb/tb_data_memory_be.sv
// Bench for data_memory_be: three instances with LATENCY 1, 2 and 3, directed steps,
// expected responses queued per instance and checked on the cycle they must appear.
module tb_data_memory_be;

   localparam int unsigned Depth = 64;
   localparam int Lat [3] = '{1, 2, 3};

   typedef struct {
      int          cyc;
      logic [31:0] rd;
      logic        err;
   } exp_t;

   logic        clk = 1'b0;
   logic        reset_s  [3];
   logic        req_s    [3];
   logic        we_s     [3];
   logic [1:0]  size_s   [3];
   logic        uns_s    [3];
   logic [31:0] a_s      [3];
   logic [31:0] wd_s     [3];
   logic        ready_s  [3];
   logic        rvalid_s [3];
   logic [31:0] rd_s     [3];
   logic        err_s    [3];

   exp_t sb [3][$];
   int   checks   = 0;
   int   failures = 0;
   int   cyc      = 0;
   bit   mon_en   = 1'b0;

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   for (genvar g = 0; g < 3; g++) begin : g_dut
      data_memory_be #(
         .DEPTH   (Depth),
         .LATENCY (g + 1)
      ) u_dut (
         .clk    (clk),
         .reset  (reset_s[g]),
         .req    (req_s[g]),
         .we     (we_s[g]),
         .size   (size_s[g]),
         .uns    (uns_s[g]),
         .a      (a_s[g]),
         .wd     (wd_s[g]),
         .ready  (ready_s[g]),
         .rvalid (rvalid_s[g]),
         .rd     (rd_s[g]),
         .err    (err_s[g])
      );
   end

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   // Response monitor: expected responses must appear exactly on their cycle, nothing else.
   always @(negedge clk) begin
      if (mon_en) begin
         for (int i = 0; i < 3; i++) begin
            if (sb[i].size() != 0 && sb[i][0].cyc == cyc) begin
               chk($sformatf("L%0d_rvalid", i + 1), {31'b0, rvalid_s[i]}, 32'd1);
               chk($sformatf("L%0d_rd", i + 1), rd_s[i], sb[i][0].rd);
               chk($sformatf("L%0d_err", i + 1), {31'b0, err_s[i]}, {31'b0, sb[i][0].err});
               void'(sb[i].pop_front());
            end else begin
               chk($sformatf("L%0d_quiet_rvalid_err_rd", i + 1),
                   rd_s[i] | {30'b0, err_s[i], rvalid_s[i]}, 32'h0);
            end
         end
      end
   end

   task automatic step(input int d, input logic r, input logic w, input logic [1:0] sz,
                       input logic u, input logic [31:0] ad, input logic [31:0] wdat,
                       input logic exp_rdy, input logic [31:0] exp_rd, input logic exp_err);
      exp_t e;
      @(negedge clk); #1;
      for (int i = 0; i < 3; i++) req_s[i] = 1'b0;
      req_s[d]  = r;
      we_s[d]   = w;
      size_s[d] = sz;
      uns_s[d]  = u;
      a_s[d]    = ad;
      wd_s[d]   = wdat;
      chk($sformatf("L%0d_ready_a%h", d + 1, ad), {31'b0, ready_s[d]}, {31'b0, exp_rdy});
      if (r && exp_rdy) begin
         e.cyc = cyc + Lat[d];
         e.rd  = exp_rd;
         e.err = exp_err;
         sb[d].push_back(e);
      end
   endtask

   task automatic ld(input int d, input logic [1:0] sz, input logic u, input logic [31:0] ad,
                     input logic [31:0] exp_rd, input logic exp_err);
      step(d, 1'b1, 1'b0, sz, u, ad, 32'h0, 1'b1, exp_rd, exp_err);
   endtask

   task automatic st(input int d, input logic [1:0] sz, input logic [31:0] ad,
                     input logic [31:0] wdat, input logic exp_err);
      step(d, 1'b1, 1'b1, sz, 1'b0, ad, wdat, 1'b1, 32'h0, exp_err);
   endtask

   task automatic idle(input int d, input logic exp_rdy);
      step(d, 1'b0, 1'b0, 2'b00, 1'b0, 32'h0, 32'h0, exp_rdy, 32'h0, 1'b0);
   endtask

   // One-cycle reset, optionally with a simultaneous word store that must be dropped.
   task automatic rst(input int d, input logic with_store, input logic [31:0] ad,
                      input logic [31:0] wdat);
      @(negedge clk); #1;
      for (int i = 0; i < 3; i++) req_s[i] = 1'b0;
      reset_s[d] = 1'b1;
      sb[d].delete();
      if (with_store) begin
         req_s[d]  = 1'b1;
         we_s[d]   = 1'b1;
         size_s[d] = 2'b10;
         a_s[d]    = ad;
         wd_s[d]   = wdat;
      end
      @(negedge clk); #1;
      reset_s[d] = 1'b0;
      req_s[d]   = 1'b0;
      chk($sformatf("L%0d_ready_after_reset", d + 1), {31'b0, ready_s[d]}, 32'd1);
   endtask

   initial begin
      for (int i = 0; i < 3; i++) begin
         reset_s[i] = 1'b1;
         req_s[i]   = 1'b0;
         we_s[i]    = 1'b0;
         size_s[i]  = 2'b00;
         uns_s[i]   = 1'b0;
         a_s[i]     = 32'h0;
         wd_s[i]    = 32'h0;
      end
      repeat (2) @(posedge clk);
      @(negedge clk); #1;
      for (int i = 0; i < 3; i++) reset_s[i] = 1'b0;
      for (int i = 0; i < 3; i++) begin
         chk($sformatf("L%0d_reset_ready", i + 1), {31'b0, ready_s[i]}, 32'd1);
         chk($sformatf("L%0d_reset_rvalid", i + 1), {31'b0, rvalid_s[i]}, 32'd0);
         chk($sformatf("L%0d_reset_rd", i + 1), rd_s[i], 32'h0);
         chk($sformatf("L%0d_reset_err", i + 1), {31'b0, err_s[i]}, 32'd0);
      end
      mon_en = 1'b1;

      // LATENCY=1: lane extraction and extension, all back-to-back through RESP
      ld(0, 2'b10, 1'b0, 32'h80, 32'h0, 1'b0);
      st(0, 2'b10, 32'h10, 32'h8899AABB, 1'b0);
      ld(0, 2'b00, 1'b0, 32'h13, 32'hFFFFFF88, 1'b0);
      ld(0, 2'b00, 1'b1, 32'h13, 32'h00000088, 1'b0);
      ld(0, 2'b01, 1'b0, 32'h10, 32'hFFFFAABB, 1'b0);
      ld(0, 2'b01, 1'b1, 32'h12, 32'h00008899, 1'b0);
      ld(0, 2'b00, 1'b0, 32'h10, 32'hFFFFFFBB, 1'b0);
      ld(0, 2'b00, 1'b1, 32'h11, 32'h000000AA, 1'b0);
      st(0, 2'b01, 32'h22, 32'hDEAD1234, 1'b0);
      ld(0, 2'b10, 1'b0, 32'h20, 32'h12340000, 1'b0);
      ld(0, 2'b01, 1'b0, 32'h22, 32'h00001234, 1'b0);
      st(0, 2'b00, 32'h21, 32'hFFFFFF77, 1'b0);
      ld(0, 2'b10, 1'b0, 32'h20, 32'h12347700, 1'b0);
      ld(0, 2'b00, 1'b0, 32'h21, 32'h00000077, 1'b0);

      // Error requests leave memory untouched
      st(0, 2'b10, 32'h11, 32'hFFFFFFFF, 1'b1);
      ld(0, 2'b01, 1'b0, 32'h05, 32'h0, 1'b1);
      st(0, 2'b01, 32'h13, 32'h0000FFFF, 1'b1);
      ld(0, 2'b11, 1'b1, 32'h10, 32'h0, 1'b1);
      st(0, 2'b11, 32'h10, 32'h0, 1'b1);
      ld(0, 2'b10, 1'b0, 32'h10, 32'h8899AABB, 1'b0);
      st(0, 2'b10, 32'h100, 32'hDEADBEEF, 1'b1);
      ld(0, 2'b10, 1'b0, 32'h100, 32'h0, 1'b1);
      ld(0, 2'b10, 1'b0, 32'h0, 32'h0, 1'b0);

      // Store then load of the same word accepted in RESP
      st(0, 2'b10, 32'h40, 32'h5, 1'b0);
      ld(0, 2'b10, 1'b0, 32'h40, 32'h5, 1'b0);
      idle(0, 1'b1);

      // Reset beats a simultaneous store; memory survives reset
      rst(0, 1'b1, 32'h44, 32'hFFFFFFFF);
      ld(0, 2'b10, 1'b0, 32'h44, 32'h0, 1'b0);
      ld(0, 2'b10, 1'b0, 32'h40, 32'h5, 1'b0);
      idle(0, 1'b1);

      // LATENCY=2: reset in WAIT drops the response; reset in RESP keeps the store
      ld(1, 2'b10, 1'b0, 32'h0, 32'h0, 1'b0);
      rst(1, 1'b0, 32'h0, 32'h0);
      st(1, 2'b10, 32'h4, 32'h11223344, 1'b0);
      idle(1, 1'b0);
      rst(1, 1'b0, 32'h0, 32'h0);
      ld(1, 2'b10, 1'b0, 32'h4, 32'h11223344, 1'b0);
      idle(1, 1'b0);
      idle(1, 1'b1);

      // LATENCY=3: two WAIT cycles, requests there are ignored
      ld(2, 2'b10, 1'b0, 32'h0, 32'h0, 1'b0);
      step(2, 1'b1, 1'b0, 2'b10, 1'b0, 32'h4, 32'h0, 1'b0, 32'h0, 1'b0);
      step(2, 1'b1, 1'b1, 2'b10, 1'b0, 32'h8, 32'hAB, 1'b0, 32'h0, 1'b0);
      ld(2, 2'b10, 1'b0, 32'h8, 32'h0, 1'b0);
      idle(2, 1'b0);
      idle(2, 1'b0);
      st(2, 2'b10, 32'hC, 32'hCAFEF00D, 1'b0);
      idle(2, 1'b0);
      idle(2, 1'b0);
      ld(2, 2'b00, 1'b0, 32'hE, 32'hFFFFFFFE, 1'b0);
      idle(2, 1'b0);
      idle(2, 1'b0);
      ld(2, 2'b01, 1'b1, 32'hC, 32'h0000F00D, 1'b0);
      idle(2, 1'b0);
      idle(2, 1'b0);
      idle(2, 1'b1);

      for (int n = 0; n < 4; n++) idle(0, 1'b1);
      for (int i = 0; i < 3; i++) begin
         chk($sformatf("L%0d_responses_outstanding", i + 1), sb[i].size(), 32'd0);
      end

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
